csa_serial_adder: RTL and testbench
===================================

# csa_serial_adder

Sequencer that reuses one 4-bit `carry_select_adder` to perform a wide (4×NIBBLES-bit) addition, one nibble per clock, LSB nibble first. It accepts operands over a valid/ready handshake and holds the result until it is consumed, so a single small adder can serve a wide datapath at reduced throughput.

## Interface
- `NIBBLES`, default 4: operand width in nibbles. Operand width W = 4·NIBBLES. Legal range is ≥1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand request.
- `in_ready` out 1: block can accept operands. High only in IDLE.
- `a` in W: operand A, sampled on accept.
- `b` in W: operand B, sampled on accept.
- `cin` in 1: carry-in, sampled on accept.
- `out_valid` out 1: result available. High only in DONE.
- `out_ready` in 1: consumer takes the result.
- `sum` out W: result register.
- `cout` out 1: final carry out.
- `busy` out 1: high in RUN or DONE.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready` = 1.
  - On `in_valid & in_ready`: latch `a`, `b` into the operand registers, load the carry register with `cin`, set nibble index idx = 0, then go to RUN.
- **RUN**
  - The adder sees nibble idx of A and B, with the carry register as its cin.
  - At the clock edge, the adder sum is written into `sum[4·idx +: 4]` and the adder carry goes into the carry register.
  - If idx == NIBBLES−1, go to DONE and load `cout` with the adder carry. Otherwise increment idx.
- **DONE**
  - `out_valid` = 1. `sum` and `cout` are held stable.
  - On `out_ready`, go to IDLE.
- `in_valid` is ignored outside IDLE. While `in_ready` is low, `a`, `b` and `cin` are not sampled.
- Arithmetic: `{cout, sum}` = `a + b + cin`, exact across all W+1 bits. Nibbles not yet processed in the current operation keep their previous values.
- `sum` is meaningful only while `out_valid` is high. During RUN it shows partial results.
- idx width is max(1, ⌈log2 NIBBLES⌉). idx never exceeds NIBBLES−1 and does not wrap.

## Timing
- Reset values: state = IDLE, idx = 0, operand and carry registers = 0, `sum` = 0, `cout` = 0, `out_valid` = 0, `busy` = 0, `in_ready` = 1.
- Reset asserted in RUN or DONE aborts the operation. No `out_valid` pulse is produced, and the next accepted operation is unaffected.
- Latency: accept at edge T. RUN occupies edges T+1 … T+NIBBLES. `out_valid` rises after edge T+NIBBLES.
- Best-case throughput (with `out_ready` held high): one operation per NIBBLES+2 cycles.
- When `out_valid & out_ready` occur in the same cycle, the block is in IDLE on the next cycle with `in_ready` = 1. Accept and release never overlap.
- `in_ready`, `out_valid` and `busy` are decoded directly from the state register. There is no combinational path from `in_valid` or `out_ready` to any output.

## Structure
- Shared package `csa_pkg` holds:
  - the state encoding (IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2);
  - `NIBBLE_W` = 4, the per-slice width of `carry_select_adder`.
- Exactly one sub-module: the existing 4-bit `carry_select_adder`, instantiated once. The nibble mux feeding it and the demux writing `sum` live in this block.
- The FSM, index counter, carry register and operand/result registers form a single sequential block.

## Test plan
- NIBBLES=4, a=0x1234, b=0x4321, cin=0 → `sum`=0x5555, `cout`=0. `out_valid` rises exactly 4 cycles after the accept edge.
- NIBBLES=4, a=0xFFFF, b=0x0000, cin=1 → carry ripples through all nibbles: `sum`=0x0000, `cout`=1.
- NIBBLES=4, a=0x8000, b=0x8000, cin=1 → `sum`=0x0001, `cout`=1.
- Backpressure: hold `out_ready` low for 5 cycles in DONE and drive `in_valid` with new operands.
  - `sum` and `cout` stay stable, `in_ready` stays 0, and the new operands are ignored.
  - After `out_ready`=1 for one cycle, the block is in IDLE and `in_ready`=1.
- Assert `rst` two cycles into RUN → all outputs take their reset values immediately, and `out_valid` never pulses. A following operation a=0x0FF0, b=0x0011, cin=0 yields `sum`=0x1001, `cout`=0.
- NIBBLES=1, a=0xE, b=0xE, cin=1 → `sum`=0xD, `cout`=1, with `out_valid` 1 cycle after accept.

Source files
------------

// File: rtl/csa_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding and slice width.
package csa_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int NIBBLE_W = 4;
endpackage

// File: rtl/csa_serial_adder_if.sv
// Operand/result handshake bundle for csa_serial_adder; master drives operands.
interface csa_serial_adder_if #(parameter int NIBBLES = 4);
  import csa_pkg::*;
  localparam int W = NIBBLE_W * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/csa_serial_adder_csa.sv
// 4-bit carry-select adder: low half ripples, high half is precomputed for both
// carry values and picked by the low-half carry.
module carry_select_adder
  import csa_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                cin_i,
  output logic [NIBBLE_W-1:0] sum_o,
  output logic                cout_o
);
  logic [2:0] lo;
  logic [2:0] hi0;
  logic [2:0] hi1;

  assign lo  = {1'b0, a_i[1:0]} + {1'b0, b_i[1:0]} + {2'b00, cin_i};
  assign hi0 = {1'b0, a_i[3:2]} + {1'b0, b_i[3:2]};
  assign hi1 = hi0 + 3'd1;

  assign sum_o  = {lo[2] ? hi1[1:0] : hi0[1:0], lo[1:0]};
  assign cout_o = lo[2] ? hi1[2] : hi0[2];
endmodule

// File: rtl/csa_serial_adder.sv
// Wide adder built from one shared 4-bit carry-select slice, one nibble per
// clock, LSB first; result held until the consumer takes it.
module csa_serial_adder
  import csa_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  csa_serial_adder_if.slave bus
);
  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  logic [1:0]          state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic                c_q;
  logic [W-1:0]        sum_q;
  logic                cout_q;

  logic [NIBBLE_W-1:0] nib_a;
  logic [NIBBLE_W-1:0] nib_b;
  logic [NIBBLE_W-1:0] add_sum;
  logic                add_cout;
  logic                last;

  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        nib_a = a_q[i*NIBBLE_W +: NIBBLE_W];
        nib_b = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  carry_select_adder u_csa (
    .a_i    (nib_a),
    .b_i    (nib_b),
    .cin_i  (c_q),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  assign last = (idx_q == IDX_W'(NIBBLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          a_q     <= bus.a;
          b_q     <= bus.b;
          c_q     <= bus.cin;
          idx_q   <= '0;
          state_q <= RUN;
        end
        RUN: begin
          for (int i = 0; i < NIBBLES; i++)
            if (idx_q == IDX_W'(i)) sum_q[i*NIBBLE_W +: NIBBLE_W] <= add_sum;
          c_q <= add_cout;
          if (last) begin
            cout_q  <= add_cout;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        DONE: if (bus.out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode state only; no input-to-output combinational path.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == RUN) || (state_q == DONE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule

// File: tb/tb_csa_serial_adder.sv
// Directed bench for csa_serial_adder at NIBBLES=4 and NIBBLES=1.
module tb_csa_serial_adder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  csa_serial_adder_if #(.NIBBLES(4)) bus4 ();
  csa_serial_adder_if #(.NIBBLES(1)) bus1 ();

  csa_serial_adder #(.NIBBLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  csa_serial_adder #(.NIBBLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Accept one operation on dut4, check latency and result, then release it.
  task automatic op4(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic cin, input logic [15:0] es, input logic ec);
    int cyc;
    @(negedge clk);
    check({tag, " in_ready"}, 32'(bus4.in_ready), 32'd1);
    bus4.a = a; bus4.b = b; bus4.cin = cin; bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    cyc = 0;
    while (!bus4.out_valid && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'd4);
    check({tag, " sum"}, 32'(bus4.sum), 32'(es));
    check({tag, " cout"}, 32'(bus4.cout), 32'(ec));
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
    check({tag, " idle after release"}, {30'd0, bus4.in_ready, bus4.out_valid}, 32'b10);
  endtask

  initial begin
    int pulses;
    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[2] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1};
    vecs[3] = '{16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};

    bus4.in_valid = 0; bus4.a = 0; bus4.b = 0; bus4.cin = 0; bus4.out_ready = 0;
    bus1.in_valid = 0; bus1.a = 0; bus1.b = 0; bus1.cin = 0; bus1.out_ready = 0;

    repeat (2) @(posedge clk);
    #1;
    check("reset4 flags", {29'd0, bus4.in_ready, bus4.out_valid, bus4.busy}, 32'b100);
    check("reset4 sum/cout", {15'd0, bus4.cout, bus4.sum}, 32'd0);
    check("reset1 flags", {29'd0, bus1.in_ready, bus1.out_valid, bus1.busy}, 32'b100);
    @(negedge clk) rst = 1'b0;

    foreach (vecs[i])
      op4($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);

    // Backpressure: hold result while new operands are offered.
    op4("bp pre", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    @(negedge clk);
    bus4.a = 16'h00FF; bus4.b = 16'h0001; bus4.cin = 1'b0; bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("bp out_valid", 32'(bus4.out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      bus4.a = 16'hFFFF; bus4.b = 16'hFFFF; bus4.cin = 1'b1; bus4.in_valid = 1'b1;
      @(posedge clk); #1;
      check($sformatf("bp hold%0d sum", k), 32'(bus4.sum), 32'h0100);
      check($sformatf("bp hold%0d flags", k),
            {28'd0, bus4.cout, bus4.in_ready, bus4.out_valid, bus4.busy}, 32'b0011);
    end
    @(negedge clk);
    bus4.in_valid = 1'b0; bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
    check("bp release", {29'd0, bus4.in_ready, bus4.out_valid, bus4.busy}, 32'b100);
    repeat (2) @(posedge clk);
    #1;
    check("bp ignored ops", {29'd0, bus4.in_ready, bus4.out_valid, bus4.busy}, 32'b100);

    // Reset two cycles into RUN aborts the operation.
    @(negedge clk);
    bus4.a = 16'h1234; bus4.b = 16'h4321; bus4.cin = 1'b0; bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("run partial sum", 32'(bus4.sum[7:0]), 32'h55);
    rst = 1'b1;
    #1;
    check("abort flags", {29'd0, bus4.in_ready, bus4.out_valid, bus4.busy}, 32'b100);
    check("abort sum/cout", {15'd0, bus4.cout, bus4.sum}, 32'd0);
    @(negedge clk) rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (bus4.out_valid) pulses++;
    end
    check("abort no out_valid", 32'(pulses), 32'd0);
    op4("post reset", 16'h0FF0, 16'h0011, 1'b0, 16'h1001, 1'b0);

    // NIBBLES=1: single RUN cycle.
    @(negedge clk);
    bus1.a = 4'hE; bus1.b = 4'hE; bus1.cin = 1'b1; bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    check("n1 busy in run", {30'd0, bus1.busy, bus1.out_valid}, 32'b10);
    @(posedge clk); #1;
    check("n1 out_valid", 32'(bus1.out_valid), 32'd1);
    check("n1 sum", 32'(bus1.sum), 32'hD);
    check("n1 cout", 32'(bus1.cout), 32'd1);
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
    check("n1 release", {30'd0, bus1.in_ready, bus1.out_valid}, 32'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
